// File: rtl/sign_stabilizer.sv
// Debounces the classifier's gesture code across video frames and commits a sign
// once it has been seen on HOLD_FRAMES consecutive frame ticks; releases on timeout.
module sign_stabilizer #(
    parameter int unsigned HOLD_FRAMES = 8,
    parameter int unsigned TIMEOUT_CYC = 2000000,
    parameter int unsigned TO_W        = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic [3:0] sign_in,
    output logic [3:0] stable_sign,
    output logic       sign_valid,
    output logic       sign_event,
    output logic       sign_release
);

    typedef enum logic {
        S_NONE,
        S_LOCK
    } state_t;

    localparam logic [3:0]      NO_SIGN = 4'd10;
    localparam logic [3:0]      HOLD    = 4'(HOLD_FRAMES);
    localparam logic [TO_W-1:0] TO_LIM  = TO_W'(TIMEOUT_CYC);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    state_t          state, state_n;
    logic [3:0]      cand, cand_n;
    logic [3:0]      cnt, cnt_n;
    logic [TO_W-1:0] to_cnt, to_n;
    logic [3:0]      stable_n;
    logic            valid_n, event_n, release_n;
    logic [3:0]      norm;
    logic            qualify;

    always_comb begin
        state_n   = state;
        cand_n    = cand;
        cnt_n     = cnt;
        to_n      = to_cnt;
        stable_n  = stable_sign;
        valid_n   = sign_valid;
        event_n   = 1'b0;
        release_n = 1'b0;
        qualify   = 1'b0;
        norm      = (sign_in == 4'd0 || sign_in > NO_SIGN) ? NO_SIGN : sign_in;

        if (frame_tick) begin
            to_n = '0;
            if (norm == cand) begin
                if (cnt != HOLD) cnt_n = cnt + 4'd1;
            end else begin
                cand_n = norm;
                cnt_n  = 4'd1;
            end
            qualify = (cnt_n == HOLD);
        end else if (to_cnt != TO_LIM) begin
            // Counter parks at TO_LIM after firing so a long stall releases only once.
            to_n = to_cnt + TO_W'(1);
            if (to_cnt == TO_LAST) begin
                cand_n = NO_SIGN;
                cnt_n  = '0;
                if (state == S_LOCK) begin
                    state_n   = S_NONE;
                    stable_n  = NO_SIGN;
                    valid_n   = 1'b0;
                    release_n = 1'b1;
                end
            end
        end

        if (qualify) begin
            case (state)
                S_NONE: begin
                    if (cand_n != NO_SIGN) begin
                        state_n  = S_LOCK;
                        stable_n = cand_n;
                        valid_n  = 1'b1;
                        event_n  = 1'b1;
                    end
                end
                S_LOCK: begin
                    if (cand_n == NO_SIGN) begin
                        state_n   = S_NONE;
                        stable_n  = NO_SIGN;
                        valid_n   = 1'b0;
                        release_n = 1'b1;
                    end else if (cand_n != stable_sign) begin
                        stable_n = cand_n;
                        event_n  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= S_NONE;
            cand         <= NO_SIGN;
            cnt          <= '0;
            to_cnt       <= '0;
            stable_sign  <= NO_SIGN;
            sign_valid   <= 1'b0;
            sign_event   <= 1'b0;
            sign_release <= 1'b0;
        end else begin
            state        <= state_n;
            cand         <= cand_n;
            cnt          <= cnt_n;
            to_cnt       <= to_n;
            stable_sign  <= stable_n;
            sign_valid   <= valid_n;
            sign_event   <= event_n;
            sign_release <= release_n;
        end
    end

endmodule

// File: tb/tb_sign_stabilizer.sv
// Scoreboard bench: two stabilizers (HOLD 8 and HOLD 1) share stimulus and are
// compared every cycle against a run-length reference model.
module tb_sign_stabilizer;

    localparam int TMO = 100;

    logic       clk = 1'b0;
    logic       rst, frame_tick;
    logic [3:0] sign_in;
    logic [3:0] sa, sb;
    logic       va, vb, ea, eb, ra, rb;

    always #5 clk = ~clk;

    sign_stabilizer #(.HOLD_FRAMES(8), .TIMEOUT_CYC(TMO), .TO_W(8)) dut_a (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .sign_in(sign_in),
        .stable_sign(sa), .sign_valid(va), .sign_event(ea), .sign_release(ra)
    );

    sign_stabilizer #(.HOLD_FRAMES(1), .TIMEOUT_CYC(TMO), .TO_W(8)) dut_b (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .sign_in(sign_in),
        .stable_sign(sb), .sign_valid(vb), .sign_event(eb), .sign_release(rb)
    );

    typedef struct packed {
        int         last;
        int         run;
        int         stall;
        logic [3:0] committed;
        logic       ev;
        logic       rel;
    } model_t;

    typedef struct packed {
        logic [3:0] sign;
        logic       valid;
        logic       ev;
        logic       rel;
    } exp_t;

    exp_t   qa[$], qb[$];
    exp_t   xa, xb;
    model_t ma, mb;
    int     checks = 0;
    int     errors = 0;

    // Committed value = value of the latest run of identical samples at least
    // `hold` long; a stall of `tmo` cycles forgets the run and drops the sign.
    function automatic model_t mstep(model_t m, int hold, int tmo,
                                     bit rst_n, bit tick, logic [3:0] s);
        model_t r = m;
        int     norm;
        r.ev  = 1'b0;
        r.rel = 1'b0;
        if (!rst_n) begin
            r.last = 10; r.run = 0; r.stall = 0; r.committed = 4'd10;
            return r;
        end
        norm = (s >= 1 && s <= 10) ? int'(s) : 10;
        if (tick) begin
            r.stall = 0;
            if (norm == r.last) r.run = r.run + 1;
            else begin r.last = norm; r.run = 1; end
            if (r.run >= hold && norm != int'(r.committed)) begin
                if (norm == 10) r.rel = 1'b1; else r.ev = 1'b1;
                r.committed = 4'(norm);
            end
        end else begin
            r.stall = r.stall + 1;
            if (r.stall == tmo) begin
                r.last = 10;
                r.run  = 0;
                if (r.committed != 4'd10) begin
                    r.rel = 1'b1;
                    r.committed = 4'd10;
                end
            end
        end
        return r;
    endfunction

    function automatic exp_t to_exp(model_t m);
        exp_t e;
        e.sign  = m.committed;
        e.valid = (m.committed != 4'd10);
        e.ev    = m.ev;
        e.rel   = m.rel;
        return e;
    endfunction

    task automatic check(string name, logic [3:0] got, logic [3:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0d want %0d at %0t", name, got, want, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (qa.size() > 0) begin
            xa = qa.pop_front();
            check("a.stable_sign",  sa,        xa.sign);
            check("a.sign_valid",   {3'b0, va}, {3'b0, xa.valid});
            check("a.sign_event",   {3'b0, ea}, {3'b0, xa.ev});
            check("a.sign_release", {3'b0, ra}, {3'b0, xa.rel});
        end
        if (qb.size() > 0) begin
            xb = qb.pop_front();
            check("b.stable_sign",  sb,        xb.sign);
            check("b.sign_valid",   {3'b0, vb}, {3'b0, xb.valid});
            check("b.sign_event",   {3'b0, eb}, {3'b0, xb.ev});
            check("b.sign_release", {3'b0, rb}, {3'b0, xb.rel});
        end
    end

    task automatic step(bit r, bit t, logic [3:0] s);
        @(negedge clk);
        rst        = r;
        frame_tick = t;
        sign_in    = s;
        ma = mstep(ma, 8, TMO, r, t, s);
        mb = mstep(mb, 1, TMO, r, t, s);
        qa.push_back(to_exp(ma));
        qb.push_back(to_exp(mb));
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++)
            step(1'b1, 1'b0, ($urandom_range(0, 1) == 0) ? 4'd9 : 4'($urandom));
    endtask

    task automatic ticks(logic [3:0] s, int n);
        for (int i = 0; i < n; i++) begin
            idle($urandom_range(0, 2));
            step(1'b1, 1'b1, s);
        end
    endtask

    initial begin
        rst = 1'b0; frame_tick = 1'b0; sign_in = 4'd0;
        ma = '0; mb = '0;

        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 4'd5);
        ticks(4'd5, 7);
        step(1'b0, 1'b1, 4'd5);
        ticks(4'd5, 7);
        ticks(4'd5, 1);

        ticks(4'd3, 8);
        ticks(4'd3, 12);

        ticks(4'd11, 8);
        ticks(4'd3, 7);
        ticks(4'd4, 1);
        ticks(4'd3, 7);
        ticks(4'd3, 1);

        ticks(4'd5, 8);
        ticks(4'd15, 8);
        ticks(4'd5, 8);

        ticks(4'd7, 8);
        idle(130);
        ticks(4'd7, 8);
        idle(99);
        step(1'b1, 1'b1, 4'd7);
        idle(20);

        for (int k = 0; k < 6; k++) begin
            ticks(4'd2, 1);
            ticks(4'd9, 1);
            ticks(4'd10, 1);
        end

        for (int k = 0; k < 400; k++) begin
            int pick;
            logic [3:0] s;
            pick = $urandom_range(0, 99);
            case ($urandom_range(0, 5))
                0: s = 4'd1;
                1: s = 4'd2;
                2: s = 4'd10;
                3: s = 4'd0;
                4: s = 4'd13;
                default: s = 4'($urandom);
            endcase
            if (pick < 2) step(1'b0, $urandom_range(0, 1) == 1, s);
            else if (pick < 6) idle($urandom_range(95, 130));
            else ticks(s, $urandom_range(1, 10));
        end

        idle(2);
        repeat (2) @(posedge clk);
        #3;
        checks++;
        if (qa.size() != 0 || qb.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d want 0", qa.size() + qb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
